wb_commit_arb: RTL and testbench

Per-issue-slice commit arbiter that merges result streams from the execute units (ALU, LSU, FPU, SFU, optional tensor) into the single writeback stream consumed by the issue stage's scoreboard and register-file write port. It grants one unit per cycle round-robin and keeps multi-packet responses (eop=0 … eop=1) contiguous. It registers the winner onto the writeback bus, which has no backpressure. One instance per issue slice.

---
 rtl/wb_commit_pkg.sv | 32 +++
 rtl/wb_rr_arbiter.sv | 51 +++++
 rtl/wb_commit_arb.sv | 106 ++++++++++
 tb/tb_wb_commit_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared types and helpers for the writeback commit arbiter.
// wb_data_t is the packet carried on every commit input and on the
// writeback bus; field order is uuid, wid, tmask, pc, wb, rd, data, eop.
package wb_commit_pkg;

    localparam int NUM_THREADS   = 4;
    localparam int XLEN          = 32;
    localparam int NR_BITS       = 6;
    localparam int NW_BITS       = 2;
    localparam int UUID_WIDTH    = 44;
    localparam int PERF_CTR_BITS = 32;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]       uuid;
        logic [NW_BITS-1:0]          wid;
        logic [NUM_THREADS-1:0]      tmask;
        logic [XLEN-1:0]             pc;
        logic                        wb;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic                        eop;
    } wb_data_t;

    localparam int WB_DATAW = $bits(wb_data_t);

    // Width of a unit index / pointer; never less than one bit so a
    // single-unit build still has a legal (constant) pointer.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin picker: combinational grant of the first request at or after
// the stored pointer (wrapping), plus the pointer register itself. When
// update_en is high and a grant exists, the pointer advances to the unit
// after the winner; otherwise it holds.
module wb_rr_arbiter
    import wb_commit_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              req,
    input  logic                      update_en,
    output logic [N-1:0]              grant,
    output logic [idx_width(N)-1:0]   grant_idx,
    output logic                      grant_valid
);

    localparam int IW = idx_width(N);

    logic [IW-1:0] ptr;

    // First requester found walking forward from the pointer.
    always_comb begin
        int u;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        u           = 0;
        for (int i = 0; i < N; i++) begin
            u = (int'(ptr) + i) % N;
            if (!grant_valid && req[u]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(u);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner only when the caller says so.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (update_en && grant_valid) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_commit_arb.sv
// Commit arbiter: merges execute-unit result streams into one registered
// writeback stream. Round-robin between units; an eop=0 packet locks the
// arbiter onto its unit until that unit's eop=1 packet so multi-packet
// responses stay contiguous. The writeback bus has no backpressure, so a
// granted packet always transfers.
// Optional: define WB_COMMIT_ARB_PERF_EN to add the perf_stalls counter.
//
// Handshake: a unit's packet transfers in a cycle where commit_valid[u] and
// commit_ready[u] are both high; commit_ready depends only on commit_valid,
// the lock and the rr pointer. While locked, commit_ready is held on the
// locked unit even when it is idle (other units see a bubble).
module wb_commit_arb
    import wb_commit_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_UNITS-1:0]            commit_valid,
    output logic [NUM_UNITS-1:0]            commit_ready,
    input  wb_data_t [NUM_UNITS-1:0]        commit_data,
    output logic                            wb_valid,
    output wb_data_t                        wb_data
`ifdef WB_COMMIT_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]        perf_stalls
`endif
);

    localparam int LW = idx_width(NUM_UNITS);

    logic                 lock_active;
    logic [LW-1:0]        lock_idx;
    logic [NUM_UNITS-1:0] lock_onehot;
    logic [NUM_UNITS-1:0] arb_req;
    logic [NUM_UNITS-1:0] arb_grant;
    logic [LW-1:0]        arb_idx;
    logic                 arb_valid;
    wb_data_t             sel_pkt;
    logic                 arb_update;

    // Decode the locked unit and restrict requests to it while locked.
    always_comb begin
        lock_onehot           = '0;
        lock_onehot[lock_idx] = 1'b1;
        arb_req               = lock_active ? (commit_valid & lock_onehot) : commit_valid;
    end

    wb_rr_arbiter #(
        .N (NUM_UNITS)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (arb_req),
        .update_en   (arb_update),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Ready follows the lock when held, else the rr grant; forced low in reset.
    always_comb begin
        commit_ready = '0;
        sel_pkt      = commit_data[arb_idx];
        arb_update   = arb_valid && sel_pkt.eop;
        if (!reset) begin
            commit_ready = lock_active ? lock_onehot : arb_grant;
        end
    end

    // Register the winning packet onto the writeback bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else begin
            wb_valid <= arb_valid;
            if (arb_valid) begin
                wb_data <= sel_pkt;
            end
        end
    end

    // Lock tracking: eop=0 holds the arbiter on the winner, eop=1 frees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (arb_valid) begin
            lock_active <= !sel_pkt.eop;
            lock_idx    <= arb_idx;
        end
    end

`ifdef WB_COMMIT_ARB_PERF_EN
    // Count cycles in which some valid unit is being held off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (|(commit_valid & ~commit_ready)) begin
            perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_arb.sv
// Bench for wb_commit_arb: directed scenarios plus randomized traffic,
// all checked against a packet-level model of the arbitration rules.
module tb_wb_commit_arb;
    import wb_commit_pkg::*;

    localparam int N = 4;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         commit_valid = '0;
    logic [N-1:0]         commit_ready;
    wb_data_t [N-1:0]     commit_data  = '0;
    logic                 wb_valid;
    wb_data_t             wb_data;
`ifdef WB_COMMIT_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls;
    logic [PERF_CTR_BITS-1:0] m_perf = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    wb_commit_arb #(.NUM_UNITS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_data  (commit_data),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data)
`ifdef WB_COMMIT_ARB_PERF_EN
        ,
        .perf_stalls  (perf_stalls)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model state: rr pointer, locked unit (-1 = none), expected wb outputs
    int       m_ptr  = 0;
    int       m_lock = -1;
    logic     m_wb_valid = 1'b0;
    wb_data_t m_wb_data  = '0;
    logic [N-1:0] acc_mask = '0;
    int       seq [N];

    // model + compare, once per cycle away from the active edge
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_ptr      = 0;
            m_lock     = -1;
            m_wb_valid = 1'b0;
            m_wb_data  = '0;
            acc_mask   = '0;
`ifdef WB_COMMIT_ARB_PERF_EN
            m_perf     = '0;
`endif
        end else begin : mon
            logic [N-1:0] exp_rdy;
            int g;
            chk("wb_valid", wb_valid, m_wb_valid);
            chk("wb_data", wb_data, m_wb_data);
`ifdef WB_COMMIT_ARB_PERF_EN
            chk("perf_stalls", perf_stalls, m_perf);
`endif
            exp_rdy = '0;
            g = -1;
            if (m_lock >= 0) begin
                exp_rdy[m_lock] = 1'b1;
                if (commit_valid[m_lock]) g = m_lock;
            end else begin
                for (int i = 0; i < N; i++)
                    if (g < 0 && commit_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("commit_ready", commit_ready, exp_rdy);
`ifdef WB_COMMIT_ARB_PERF_EN
            if ((commit_valid & ~exp_rdy) != '0) m_perf = m_perf + 1'b1;
`endif
            acc_mask = commit_valid & exp_rdy;
            if (g >= 0) begin
                m_wb_valid = 1'b1;
                m_wb_data  = commit_data[g];
                if (commit_data[g].eop) begin
                    m_lock = -1;
                    m_ptr  = (g + 1) % N;
                end else begin
                    m_lock = g;
                end
            end else begin
                m_wb_valid = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic set_pkt(input int u, input logic v, input logic eop);
        wb_data_t p;
        p.uuid  = {12'(u), 32'(seq[u])};
        seq[u]  = seq[u] + 1;
        p.wid   = NW_BITS'($urandom);
        p.tmask = NUM_THREADS'($urandom);
        p.pc    = XLEN'($urandom);
        p.wb    = 1'($urandom);
        p.rd    = NR_BITS'($urandom);
        p.data  = {$urandom, $urandom, $urandom, $urandom};
        p.eop   = eop;
        commit_data[u]  = p;
        commit_valid[u] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        commit_valid = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    localparam int T3_LEN = 6;
    int t3_exp [T3_LEN] = '{0, 1, 1, 1, 3, 0};

    initial begin
        for (int u = 0; u < N; u++) seq[u] = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_ready", commit_ready, 4'b0000);

        // single unit 2, eop=1, rd=5, data DEADBEEF
        do_reset();
        cyc();
        set_pkt(2, 1'b1, 1'b1);
        commit_data[2].rd = 6'd5;
        commit_data[2].data[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_ready", commit_ready, 4'b0100);
        cyc();
        commit_valid = '0;
        @(negedge clk);
        chk("t1_wb_valid", wb_valid, 1'b1);
        chk("t1_rd", wb_data.rd, 6'd5);
        chk("t1_data", wb_data.data[31:0], 32'hDEAD_BEEF);
        cyc();
        @(negedge clk);
        chk("t1_wb_idle", wb_valid, 1'b0);

        // all units valid, eop=1: rotation 0,1,2,3,0,1
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cyc();
            for (int u = 0; u < N; u++) set_pkt(u, 1'b1, 1'b1);
            @(negedge clk);
            if (k > 0) begin
                chk("t2_wb_valid", wb_valid, 1'b1);
                chk("t2_unit", wb_data.uuid[43:32], (k - 1) % 4);
            end
        end
        cyc();
        commit_valid = '0;

        // unit 1 sends eop=0,0,1 while units 0 and 3 stay valid
        do_reset();
        cyc();
        set_pkt(0, 1'b1, 1'b1);
        @(negedge clk);
        for (int k = 0; k < T3_LEN; k++) begin
            cyc();
            commit_valid = '0;
            set_pkt(0, 1'b1, 1'b1);
            set_pkt(3, 1'b1, 1'b1);
            if (k < 3) set_pkt(1, 1'b1, k == 2);
            @(negedge clk);
            chk("t3_unit", wb_data.uuid[43:32], t3_exp[k]);
        end
        cyc();
        commit_valid = '0;

        // unit 2 locked then idle for two cycles while unit 0 waits
        do_reset();
        cyc();
        set_pkt(2, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_ready_lock", commit_ready, 4'b0100);
        for (int k = 0; k < 2; k++) begin
            cyc();
            commit_valid = '0;
            set_pkt(0, 1'b1, 1'b1);
            @(negedge clk);
            chk("t4_ready_idle", commit_ready, 4'b0100);
            if (k == 1) chk("t4_bubble", wb_valid, 1'b0);
        end
        cyc();
        set_pkt(0, 1'b1, 1'b1);
        set_pkt(2, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_ready_eop", commit_ready, 4'b0100);
        chk("t4_bubble2", wb_valid, 1'b0);
        cyc();
        commit_valid = '0;
        set_pkt(0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_ready_after", commit_ready, 4'b0001);
        chk("t4_unit2", wb_data.uuid[43:32], 2);
        cyc();
        commit_valid = '0;
        @(negedge clk);
        chk("t4_unit0", wb_data.uuid[43:32], 0);

        // asynchronous reset in the middle of a locked response
        do_reset();
        cyc();
        set_pkt(1, 1'b1, 1'b0);
        @(negedge clk);
        cyc();
        for (int u = 0; u < N; u++) set_pkt(u, 1'b1, u != 1);
        @(negedge clk);
        chk("t5_ready_lock", commit_ready, 4'b0010);
        @(posedge clk);
        #3;
        chk("t5_wb_before", wb_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_wb_async", wb_valid, 1'b0);
        chk("t5_ready_async", commit_ready, 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_first_grant", commit_ready, 4'b0001);
        cyc();
        commit_valid = '0;

`ifdef WB_COMMIT_ARB_PERF_EN
        // perf counter: 4 units valid for 10 cycles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc();
            for (int u = 0; u < N; u++) set_pkt(u, 1'b1, 1'b1);
        end
        cyc();
        commit_valid = '0;
        @(negedge clk);
        chk("perf_10", perf_stalls, 32'd10);
`endif

        // randomized traffic; packets held until accepted
        do_reset();
        repeat (3000) begin
            cyc();
            for (int u = 0; u < N; u++) begin
                if (!commit_valid[u] || acc_mask[u]) begin
                    if ($urandom_range(0, 3) != 0) set_pkt(u, 1'b1, 1'($urandom_range(0, 1)));
                    else commit_valid[u] = 1'b0;
                end
            end
        end
        cyc();
        commit_valid = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
